fifo_word_serializer: RTL and testbench



---
 rtl/fifo_word_serializer.sv | 108 ++++++++++
 tb/tb_fifo_word_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - drains a wide FIFO and streams its words as narrow LSB-first slices
module fifo_word_serializer #(
  parameter int DATA_W = 256,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              eclk,
  input  logic              rstb,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy
);

  localparam int RATIO = DATA_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] pf_q, pf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pf_v_q, pf_v_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  logic accept;
  logic last_slice;
  logic rd_en;

  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      pf_q         <= '0;
      idx_q        <= '0;
      pf_v_q       <= 1'b0;
      pend_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      pf_q         <= pf_d;
      idx_q        <= idx_d;
      pf_v_q       <= pf_v_d;
      pend_q       <= pend_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    pf_d         = pf_q;
    idx_d        = idx_q;
    pf_v_d       = pf_v_q;
    word_count_d = word_count_q;

    // One outstanding word at most beyond sh; gating with rstb keeps the strobe low during reset.
    rd_en      = rstb & ~fifo_empty & ~pend_q & ~pf_v_q;
    pend_d     = rd_en;
    accept     = (state_q == SEND) & m_ready;
    last_slice = (idx_q == LAST_IDX);

    if (accept) begin
      if (last_slice) begin
        word_count_d = word_count_q + CNT_W'(1);
        if (pf_v_q) begin
          sh_d   = pf_q;
          pf_v_d = 1'b0;
          idx_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        sh_d  = sh_q >> OUT_W;
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Returning read data goes straight into sh when sh is free (or freeing this cycle).
    if (pend_q) begin
      if ((state_q == IDLE) || (accept && last_slice)) begin
        sh_d    = fifo_data;
        idx_d   = '0;
        state_d = SEND;
      end else begin
        pf_d   = fifo_data;
        pf_v_d = 1'b1;
      end
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_valid    = (state_q == SEND);
  assign m_data     = (state_q == SEND) ? sh_q[OUT_W-1:0] : '0;
  assign m_last     = (state_q == SEND) & (idx_q == LAST_IDX);
  assign word_count = word_count_q;
  assign busy       = (state_q == SEND) | pf_v_q | pend_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb/tb_fifo_word_serializer.sv - directed vector bench for fifo_word_serializer with a FIFO model
module tb_fifo_word_serializer;
  localparam int DATA_W = 256;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 4;

  logic              eclk = 1'b0;
  logic              rstb;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic [OUT_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [CNT_W-1:0]  word_count;
  logic              busy;

  fifo_word_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .eclk(eclk), .rstb(rstb), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .word_count(word_count), .busy(busy)
  );

  always #5 eclk = ~eclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model with one-cycle registered read data, plus a slice scoreboard.
  logic [DATA_W-1:0] fq[$];
  logic [OUT_W-1:0]  exp_q[$];
  logic              rd_seen = 1'b0;
  int                pulses = 0;
  int                rd_empty = 0;
  int                mon_err = 0;
  int                mon_idx = 0;
  logic              prev_stall = 1'b0;
  logic [OUT_W-1:0]  prev_data = '0;
  int                word_serial = 0;
  int                wc_exp = 0;

  always @(negedge eclk) begin
    rd_seen = fifo_rd_en;
    if (fifo_rd_en) begin
      pulses++;
      if (fifo_empty) rd_empty++;
    end
    if (prev_stall && (m_data !== prev_data)) mon_err++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) mon_err++;
      else if (m_data !== exp_q.pop_front()) mon_err++;
      if (m_last !== (mon_idx == 7)) mon_err++;
      mon_idx = (mon_idx + 1) % 8;
    end
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
  end

  always @(posedge eclk) begin
    if (rd_seen && fq.size() > 0) begin
      fifo_data  <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic push_words(input int nw);
    logic [DATA_W-1:0] w;
    for (int n = 0; n < nw; n++) begin
      for (int k = 0; k < 8; k++) begin
        w[32*k +: 32] = {16'(word_serial), 16'(k)};
        exp_q.push_back({16'(word_serial), 16'(k)});
      end
      fq.push_back(w);
      word_serial++;
    end
    fifo_empty = 1'b0;
  endtask

  typedef struct {
    int         nw;
    logic [3:0] pat;
    int         lat;
    int         span;
    int         pulses;
  } vec_t;

  task automatic do_vec(input int id, input vec_t v);
    int lat, span, gaps, t, c, lastcnt, p0, m0, first_p;
    bit done;
    lat = -1; span = 0; gaps = 0; t = 0; c = 0; lastcnt = 0; first_p = 0; done = 0;
    p0 = pulses; m0 = mon_err;
    push_words(v.nw);
    while (!done && t < 400) begin
      if (m_valid && lat < 0) lat = t;
      if (lat >= 0) begin
        m_ready = v.pat[c % 4];
        c++;
      end else begin
        m_ready = 1'b0;
      end
      @(negedge eclk);
      if (lat >= 0 && !m_valid) gaps++;
      if (m_valid && m_ready && m_last) begin
        lastcnt++;
        if (lastcnt == 1) first_p = pulses - p0;
        if (lastcnt == v.nw) begin
          done = 1;
          span = c;
        end
      end
      @(posedge eclk); #1;
      t++;
    end
    m_ready = 1'b0;
    wc_exp = (wc_exp + v.nw) % 16;
    chk($sformatf("v%0d_done", id), done, 1);
    chk($sformatf("v%0d_latency", id), lat, v.lat);
    chk($sformatf("v%0d_span", id), span, v.span);
    chk($sformatf("v%0d_gaps", id), gaps, 0);
    chk($sformatf("v%0d_rd_pulses", id), pulses - p0, v.pulses);
    chk($sformatf("v%0d_outstanding_le2", id), (first_p <= 2), 1);
    chk($sformatf("v%0d_slices", id), mon_err - m0, 0);
    chk($sformatf("v%0d_slices_left", id), exp_q.size(), 0);
    chk($sformatf("v%0d_word_count", id), word_count, wc_exp);
    chk($sformatf("v%0d_idle_after", id), {m_valid, busy}, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int acc, t, idle_err;
    vecs[0] = '{nw: 1, pat: 4'b1111, lat: 2, span: 8,  pulses: 1};
    vecs[1] = '{nw: 3, pat: 4'b1111, lat: 2, span: 24, pulses: 3};
    vecs[2] = '{nw: 1, pat: 4'b0101, lat: 2, span: 15, pulses: 1};
    vecs[3] = '{nw: 1, pat: 4'b1001, lat: 2, span: 16, pulses: 1};
    vecs[4] = '{nw: 2, pat: 4'b1001, lat: 2, span: 32, pulses: 2};
    vecs[5] = '{nw: 1, pat: 4'b0001, lat: 2, span: 29, pulses: 1};

    rstb = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    repeat (2) @(posedge eclk);
    #1;
    chk("reset_ctl", {fifo_rd_en, m_valid, m_last, busy}, 0);
    chk("reset_data", m_data, 0);
    chk("reset_count", word_count, 0);
    rstb = 1'b1;
    @(posedge eclk); #1;

    for (int i = 0; i < 6; i++) do_vec(i, vecs[i]);

    // FIFO runs dry at the end of a word; next word arrives a few cycles later.
    do_vec(10, vecs[0]);
    idle_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge eclk);
      if (m_valid || busy) idle_err++;
      @(posedge eclk); #1;
    end
    chk("gap_idle", idle_err, 0);
    do_vec(11, vecs[0]);

    // Asynchronous reset while slice 3 of the second word is on the bus.
    push_words(2);
    m_ready = 1'b1;
    acc = 0; t = 0;
    while (acc < 11 && t < 100) begin
      @(negedge eclk);
      if (m_valid && m_ready) acc++;
      @(posedge eclk); #1;
      t++;
    end
    chk("rst_reach_slice3", acc, 11);
    chk("rst_pre_data", m_data, {16'(word_serial - 1), 16'd3});
    rstb = 1'b0;
    #1;
    chk("rst_async_ctl", {fifo_rd_en, m_valid, m_last, busy}, 0);
    chk("rst_async_data", m_data, 0);
    chk("rst_async_count", word_count, 0);
    m_ready = 1'b0;
    repeat (2) @(posedge eclk);
    #1;
    exp_q.delete();
    mon_idx = 0;
    prev_stall = 1'b0;
    wc_exp = 0;
    rstb = 1'b1;
    @(posedge eclk); #1;
    chk("rst_release_idle", {m_valid, busy, word_count}, 0);
    do_vec(20, vecs[0]);

    // Counter wrap with the 4-bit build: 14 more words reach 15, one more wraps to 0.
    do_vec(30, '{nw: 14, pat: 4'b1111, lat: 2, span: 112, pulses: 14});
    chk("wrap_at_max", word_count, 15);
    do_vec(31, vecs[0]);
    chk("wrap_to_zero", word_count, 0);

    chk("rd_while_empty", rd_empty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
